shared_counter_arbiter: RTL and testbench

//  Shares one SZ-bit up-counter among NREQ requesters. Each requester asks for a timed run of len ticks.
//  A round-robin arbiter grants the counter to one requester, and an FSM sequences IDLE/RUN/DONE.
//  The block sits between client FSMs that need interval timing and the shared counter datapath.

---
 rtl/shared_counter_arbiter.sv | 154 +++++++++++++++
 tb/tb_shared_counter_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_counter_arbiter.sv
// shared_counter_arbiter
//   Shares one SZ-bit up-counter among NREQ requesters. A round-robin arbiter
//   hands the counter to one requester at a time. The owner's length is latched
//   when it is granted, and the counter then runs from 0 up to that length.
//
// Optional build macro: COUNT_GATE_EN
//   When defined, a tick_en input is added and the counter advances only on
//   RUN cycles with tick_en=1. When undefined, it advances on every RUN cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req        in   [NREQ]     per-requester request level, held until done
//   len        in   [NREQ*SZ]  per-requester length, slice i = len[i*SZ +: SZ]
//   tick_en    in   count enable (COUNT_GATE_EN builds only)
//   grant      out  [NREQ]     one-hot owner of the counter, zero when idle
//   done       out  [NREQ]     one-cycle completion pulse to the owner
//   busy       out  high in RUN and DONE
//   count_out  out  [SZ]       shared counter value
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no owner; arbitrate among pending requests
// S_RUN  | owner granted; counter advancing towards len_q
// S_DONE | run complete; done pulse to owner for one cycle

module shared_counter_arbiter #(
  parameter int NREQ = 4,
  parameter int SZ   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*SZ-1:0] len,
`ifdef COUNT_GATE_EN
  input  logic               tick_en,
`endif
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [SZ-1:0]      count_out
);

  localparam int IW = $clog2(NREQ);
  localparam logic [SZ-1:0] ONE = SZ'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [IW-1:0] ptr, ptr_d;
  logic [IW-1:0] owner, owner_d;
  logic [IW-1:0] win, cand;
  logic          found;
  logic [SZ-1:0] len_q, len_d;
  logic [SZ-1:0] cnt, cnt_d;
  logic [SZ-1:0] win_len;
  logic          adv;

`ifdef COUNT_GATE_EN
  assign adv = tick_en;
`else
  assign adv = 1'b1;
`endif

  // Round-robin search: first request found going upward from ptr+1,
  // wrapping at NREQ. ptr holds the most recent winner.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_len = len[win*SZ +: SZ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= IW'(NREQ - 1);
      owner <= '0;
      len_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      owner <= owner_d;
      len_q <= len_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    owner_d = owner;
    len_d   = len_q;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (found) begin
          // The pointer moves to the winner at grant time, so an owner that
          // later aborts has already given up its priority.
          ptr_d   = win;
          owner_d = win;
          len_d   = win_len;
          cnt_d   = '0;
          state_d = (win_len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // Abort wins over a coincident increment; the counter holds.
        if (!req[owner]) begin
          state_d = S_IDLE;
        end else if (adv) begin
          cnt_d = cnt + ONE;
          if (cnt == len_q - ONE) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    grant = '0;
    done  = '0;
    if (state != S_IDLE) begin
      grant[owner] = 1'b1;
    end
    if (state == S_DONE) begin
      done[owner] = 1'b1;
    end
  end

  assign busy      = (state != S_IDLE);
  assign count_out = cnt;

endmodule

// File: tb/tb_shared_counter_arbiter.sv
module tb_shared_counter_arbiter;

  localparam int N  = 4;
  localparam int SZ = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*SZ-1:0]   len;
  logic              tick_en;
  logic [N-1:0]      grant;
  logic [N-1:0]      done;
  logic              busy;
  logic [SZ-1:0]     count_out;

  always #5 clk = ~clk;

  shared_counter_arbiter #(.NREQ(N), .SZ(SZ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .len       (len),
`ifdef COUNT_GATE_EN
    .tick_en   (tick_en),
`endif
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .count_out (count_out)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model, transaction level: who owns the counter, how many
  // ticks it has accumulated, and whether its completion is being reported.
  int m_owner;   // -1 when nobody owns the counter
  int m_ptr;     // last winner
  int m_cnt;
  int m_len;
  bit m_done;

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = N - 1;
    m_cnt   = 0;
    m_len   = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N*SZ-1:0] l, input logic t);
    bit counts;
`ifdef COUNT_GATE_EN
    counts = t;
`else
    counts = 1'b1 | t;
`endif
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int w;
        w = (m_ptr + k) % N;
        if (m_owner < 0 && r[w]) begin
          m_owner = w;
          m_ptr   = w;
          m_len   = int'(l[w*SZ +: SZ]);
          m_cnt   = 0;
          m_done  = (m_len == 0);
        end
      end
    end else if (m_done) begin
      m_owner = -1;
      m_done  = 1'b0;
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (counts) begin
      m_cnt++;
      if (m_cnt == m_len) m_done = 1'b1;
    end
  endtask

  task automatic chk_model(input string nm);
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    chk({nm, "_grant"}, 32'(grant), 32'(eg));
    chk({nm, "_done"},  32'(done),  32'(m_done ? eg : '0));
    chk({nm, "_busy"},  32'(busy),  32'(m_owner >= 0));
    chk({nm, "_count"}, 32'(count_out), 32'(m_cnt));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic [N-1:0] r, input logic [N*SZ-1:0] l, input logic t);
    req = r;
    len = l;
    tick_en = t;
    @(posedge clk);
    model_step(r, l, t);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0]    r;
    logic [N*SZ-1:0] l;
    logic [N-1:0]    g;
    logic [N-1:0]    d;
    logic            b;
    logic [SZ-1:0]   c;
  } vec_t;

  vec_t tbl[10];
  logic [N-1:0] rr_seen[$];
  logic [N-1:0] rr_exp[5];
  logic [N-1:0] prev_g;
  logic [N-1:0] rr;
  logic [N*SZ-1:0] rl;

  initial begin
    rst_n = 1'b0;
    req = '0;
    len = '0;
    tick_en = 1'b0;
    model_reset();

    // slices: [0]=7 [1]=5 [2]=0 [3]=9; rows 2..4 change slice 1 mid-run
    tbl[0] = '{4'b0010, 32'h0900_0507, 4'b0010, 4'b0000, 1'b1, 8'd0};
    tbl[1] = '{4'b0010, 32'h0900_0507, 4'b0010, 4'b0000, 1'b1, 8'd1};
    tbl[2] = '{4'b0010, 32'h0900_0207, 4'b0010, 4'b0000, 1'b1, 8'd2};
    tbl[3] = '{4'b0010, 32'h0900_0207, 4'b0010, 4'b0000, 1'b1, 8'd3};
    tbl[4] = '{4'b0010, 32'h0900_0207, 4'b0010, 4'b0000, 1'b1, 8'd4};
    tbl[5] = '{4'b0010, 32'h0900_0507, 4'b0010, 4'b0010, 1'b1, 8'd5};
    tbl[6] = '{4'b0000, 32'h0900_0507, 4'b0000, 4'b0000, 1'b0, 8'd5};
    tbl[7] = '{4'b0100, 32'h0900_0507, 4'b0100, 4'b0100, 1'b1, 8'd0};
    tbl[8] = '{4'b0100, 32'h0900_0507, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[9] = '{4'b0000, 32'h0900_0507, 4'b0000, 4'b0000, 1'b0, 8'd0};

    #3;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done",  32'(done),  32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_count", 32'(count_out), 32'h0);
    #9 rst_n = 1'b1;
    @(negedge clk);

    // single run, len change ignored, zero-length run
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].r, tbl[i].l, 1'b1);
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_done", i),  32'(done),  32'(tbl[i].d));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),  32'(tbl[i].b));
      chk($sformatf("tbl%0d_count", i), 32'(count_out), 32'(tbl[i].c));
    end

    // asynchronous reset mid-run at count 3, no done afterwards
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0001, 32'h0303_030A, 1'b1);
      chk_model($sformatf("pre_rst%0d", i));
    end
    chk("pre_rst_count3", 32'(count_out), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_done",  32'(done),  32'h0);
    chk("async_busy",  32'(busy),  32'h0);
    chk("async_count", 32'(count_out), 32'h0);
    model_reset();
    req = '0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    cycle(4'b0000, 32'h0303_030A, 1'b1);
    chk_model("post_rst");

    // round robin with all requesting, len=2
    prev_g = '0;
    for (int i = 0; i < 20; i++) begin
      cycle(4'b1111, 32'h0202_0202, 1'b1);
      chk_model($sformatf("rr%0d", i));
      if (prev_g == '0 && grant != '0) rr_seen.push_back(grant);
      prev_g = grant;
    end
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    chk("rr_grant_count", 32'(rr_seen.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < rr_seen.size())
        chk($sformatf("rr_order%0d", i), 32'(rr_seen[i]), 32'(rr_exp[i]));
    end

    // abort at count 4, then priority moves past the aborting requester
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0001, 32'h0A0A_0A0A, 1'b1);
      chk_model($sformatf("abort_run%0d", i));
    end
    cycle(4'b0000, 32'h0A0A_0A0A, 1'b1);
    chk("abort_grant", 32'(grant), 32'h0);
    chk("abort_done",  32'(done),  32'h0);
    chk("abort_busy",  32'(busy),  32'h0);
    chk("abort_count", 32'(count_out), 32'd4);
    cycle(4'b0011, 32'h0A0A_0A0A, 1'b1);
    chk("abort_next_grant", 32'(grant), 32'b0010);
    chk_model("abort_next");

`ifdef COUNT_GATE_EN
    // gated counting: len=3, tick_en on alternate cycles
    do_reset();
    begin
      int done_at;
      done_at = -1;
      for (int k = 1; k <= 10; k++) begin
        cycle(4'b0001, 32'h0303_0303, logic'(k % 2));
        chk_model($sformatf("gate%0d", k));
        if (done[0] && done_at < 0) done_at = k;
      end
      chk("gate_done_cycle", 32'(done_at), 32'd7);
    end
`endif

    // randomized traffic against the model
    rr = 4'b0011;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
        if ($urandom_range(0, 49) == 0)
          rl[b*SZ +: SZ] = 8'd255;
        else
          rl[b*SZ +: SZ] = SZ'($urandom_range(0, 6));
      end
      cycle(rr, rl, logic'($urandom_range(0, 1)));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
